alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle datapath ALU, sitting in the execute stage of the CPU.
- Registered, handshaked: one operation in flight at a time.
- Single-cycle logic/arith/shift ops complete 1 cycle after acceptance. Iterative MULT/MULTU/DIV/DIVU take WIDTH extra cycles and produce a HI/LO pair.
- Existing control encodings are kept unchanged; new ops fill the unused codes.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- valid_i  in  1  operands/ctrl valid
- ready_o  out  1  block can accept an operation
- src1_i  in  WIDTH  operand A (signed for signed ops)
- src2_i  in  WIDTH  operand B; shift amount in [SHW-1:0]
- ctrl_i  in  4  operation code
- valid_o  out  1  result valid
- ready_i  in  1  consumer takes the result
- result_o  out  WIDTH  result; LO (low product / quotient) for mul/div
- hi_o  out  WIDTH  HI (high product / remainder) for mul/div, 0 otherwise
- zero_o  out  1  result_o == 0

Behaviour:
- ctrl_i encodings:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111
  - SLTU 1000, SRA 1001, MULT 1010, MULTU 1011, NOR 1100, DIV 1101, DIVU 1110
  - 1111 reserved: result 0, hi 0, 1-cycle latency.
- Reset (rst_i low, async): state IDLE; valid_o=0; result_o=0; hi_o=0; zero_o=1; iteration counter 0. Reset mid-iteration discards the operation and produces no output.
- FSM: IDLE, BUSY, DONE.
  - IDLE: ready_o=1. On accept (valid_i & ready_o):
    - single-cycle op: outputs registered, go to DONE;
    - mul/div: operands latched, counter=0, go to BUSY.
  - BUSY: ready_o=0; one shift-add / restoring-subtract step per cycle; after WIDTH steps, load result_o/hi_o and go to DONE.
  - DONE: valid_o=1; outputs stable until ready_i.
    - ready_i=1 and valid_i=0: go to IDLE.
    - ready_i=1 and valid_i=1: back-to-back accept in the same cycle (ready_o = IDLE | (DONE & ready_i)).
- Latency: single-cycle ops valid_o on cycle N+1 after accept at N; mul/div on N+WIDTH+1. Throughput 1 op/cycle for single-cycle ops with ready_i held high.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT signed compare, SLTU unsigned compare; result 1 or 0.
  - Shifts use src2_i[SHW-1:0] only; SRA sign-fills.
  - MULT/MULTU: full 2*WIDTH product, {hi_o,result_o}. Signed via magnitude multiply plus final negate.
  - DIV/DIVU: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: result_o all ones, hi_o = src1_i (both signednesses).
  - DIV of MIN_INT by -1: result_o=MIN_INT, hi_o=0.
- zero_o is registered with result_o: zero_o = (result_o==0). For SUB this equals the operand-equality flag.
- Inputs are ignored when ready_o=0. Operands are sampled only at accept.

Decomposition:
- Package alu_pkg: ctrl opcode localparams (4-bit), FSM state typedef, helper function is_muldiv(ctrl).
- Sub-module alu_muldiv_iter owns:
  - the iterative mul/div datapath;
  - start/done handshake with the top FSM;
  - sign fix-up and the divide-by-zero / overflow cases.
- Top keeps the single-cycle ops and the FSM.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 -> valid_o 1 cycle later; result_o=0x80000000, zero_o=0, hi_o=0.
- SUB 5-5 with ready_i held 1, followed back-to-back by SLT -3<2 -> results 0 (zero_o=1) then 1 on consecutive cycles; ready_o never drops.
- MULT 0xFFFFFFFF * 0x00000002 (-1*2) -> valid_o exactly 33 cycles after accept; hi_o=0xFFFFFFFF, result_o=0xFFFFFFFE. MULTU on the same operands -> hi_o=1, result_o=0xFFFFFFFE.
- DIV -7/2 -> result_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 7/0 -> result_o=0xFFFFFFFF, hi_o=7. DIV 0x80000000/-1 -> result_o=0x80000000, hi_o=0.
- SRA 0x80000000 by src2_i=0x24 (uses 4) -> 0xF8000000. ready_i held 0 for 5 cycles -> outputs and valid_o stable; valid_i pulses ignored.
- Assert rst_i low at BUSY step 10 of DIVU -> valid_o=0 and result_o=0 immediately. After release, a fresh ADD 1+2 -> 3, with no stale result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode helpers for the multicycle execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_RSV   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] ctrl);
    return (ctrl == OP_MULT) || (ctrl == OP_MULTU) ||
           (ctrl == OP_DIV)  || (ctrl == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up and the divide-by-zero / MIN_INT/-1 cases resolved on the last step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic             busy_q, is_div_q, neg_lo_q, neg_hi_q, dz_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] m_q, src1_q, acc_hi_q, acc_lo_q;

  logic             sgn, div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sgn   = (ctrl_i == OP_MULT) || (ctrl_i == OP_DIV);
    div   = (ctrl_i == OP_DIV)  || (ctrl_i == OP_DIVU);
    a_neg = sgn & src1_i[WIDTH-1];
    b_neg = sgn & src2_i[WIDTH-1];
    mag_a = a_neg ? -src1_i : src1_i;
    mag_b = b_neg ? -src2_i : src2_i;
  end

  // One iteration: multiply shifts {hi,lo} right after a conditional add,
  // divide shifts {rem,quot} left and keeps the trial subtract when it fits.
  logic [WIDTH:0]   sum, rem_sh;
  logic             ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    sum    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? m_q : {WIDTH{1'b0}})};
    rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, m_q};
    if (is_div_q) begin
      hi_n = ge ? WIDTH'(rem_sh - {1'b0, m_q}) : rem_sh[WIDTH-1:0];
      lo_n = {acc_lo_q[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH-1));

  logic [2*WIDTH-1:0] prod, prod_f;

  always_comb begin
    prod   = {hi_n, lo_n};
    prod_f = neg_lo_q ? -prod : prod;
    lo_o   = prod_f[WIDTH-1:0];
    hi_o   = prod_f[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      if (dz_q) begin
        lo_o = {WIDTH{1'b1}};
        hi_o = src1_q;
      end else if (ovf_q) begin
        lo_o = MIN_INT;
        hi_o = '0;
      end else begin
        lo_o = neg_lo_q ? -lo_n : lo_n;
        hi_o = neg_hi_q ? -hi_n : hi_n;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      m_q      <= '0;
      src1_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      is_div_q <= div;
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= div ? a_neg : (a_neg ^ b_neg);
      dz_q     <= div && (src2_i == '0);
      ovf_q    <= (ctrl_i == OP_DIV) && (src1_i == MIN_INT) && (&src2_i);
      m_q      <= div ? mag_b : mag_a;
      src1_q   <= src1_i;
      acc_hi_q <= '0;
      acc_lo_q <= div ? mag_a : mag_b;
    end else if (busy_q) begin
      acc_hi_q <= hi_n;
      acc_lo_q <= lo_n;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: registered single-cycle ops plus iterative mul/div behind
// a valid/ready handshake, one operation in flight.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q;

  logic             accept, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi, sc_res;
  logic [SHW-1:0]   shamt;

  assign shamt = src2_i[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (ctrl_i)
      OP_AND:  sc_res = src1_i & src2_i;
      OP_OR:   sc_res = src1_i | src2_i;
      OP_ADD:  sc_res = src1_i + src2_i;
      OP_XOR:  sc_res = src1_i ^ src2_i;
      OP_SLL:  sc_res = src1_i << shamt;
      OP_SRL:  sc_res = src1_i >> shamt;
      OP_SUB:  sc_res = src1_i - src2_i;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
      OP_SRA:  sc_res = $signed(src1_i) >>> shamt;
      OP_NOR:  sc_res = ~(src1_i | src2_i);
      default: sc_res = '0;
    endcase
  end

  // A finished result can be consumed and replaced in the same cycle.
  assign ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i);
  assign accept   = valid_i && ready_o;
  assign md_start = accept && is_muldiv(ctrl_i);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (md_start),
    .ctrl_i  (ctrl_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    case (state_q)
      ST_BUSY: begin
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_lo;
          hi_d     = md_hi;
        end
      end
      ST_DONE: if (ready_i) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (is_muldiv(ctrl_i)) begin
        state_d = ST_BUSY;
      end else begin
        state_d  = ST_DONE;
        result_d = sc_res;
        hi_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= (result_d == '0);
    end
  end

  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign zero_o   = zero_q;

endmodule
